// File: rtl/sif_bridge_fifo.sv
// Host-side shadow register file with an ordered write-forwarding FIFO toward a downstream port.
// Optional macro SIF_BRIDGE_RD_FWD_EN: a same-cycle read returns the data being written to it.
module sif_bridge_fifo #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        xa_addr,
  input  logic [DATA_W-1:0]        xa_data_wr,
  input  logic                     xa_wr_s,
  input  logic                     xa_rd_s,
  output logic [DATA_W-1:0]        xa_data_rd,
  output logic                     xa_rd_vld,
  output logic                     xa_busy,
  output logic [ADDR_W-1:0]        wa_addr,
  output logic [DATA_W-1:0]        wa_data_wr,
  output logic                     wa_wr_s,
  input  logic                     wa_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DATA_W-1:0] shadow_q [NUM_REGS];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [DATA_W-1:0] rd_data_q, rd_val;
  logic              rd_vld_q, ovf_q;

  logic [IDX_W-1:0]  idx;
  logic              in_range, full, not_empty, push, pop, shadow_wr;

  assign idx       = xa_addr[IDX_W-1:0];
  assign in_range  = (xa_addr >> IDX_W) == '0;
  // Busy comes from the registered level only, so a same-cycle pop never admits a push.
  assign full      = (level_q == LVL_W'(DEPTH));
  assign not_empty = (level_q != '0);
  assign push      = xa_wr_s & ~full;
  assign pop       = not_empty & wa_ready;
  assign shadow_wr = push & in_range;

  always_comb begin
    rd_val = '0;
    if (in_range) rd_val = shadow_q[idx];
`ifdef SIF_BRIDGE_RD_FWD_EN
    // Read and write share xa_addr, so an accepted in-range write always hits the read index.
    if (shadow_wr) rd_val = xa_data_wr;
`else
    rd_val = rd_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
      if (xa_wr_s && full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_mem[wr_ptr_q] <= xa_addr;
      data_mem[wr_ptr_q] <= xa_data_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) shadow_q[i] <= '0;
    end else if (shadow_wr) begin
      shadow_q[idx] <= xa_data_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= xa_rd_s;
      if (xa_rd_s) rd_data_q <= rd_val;
    end
  end

  assign xa_data_rd = rd_data_q;
  assign xa_rd_vld  = rd_vld_q;
  assign xa_busy    = full;
  assign fifo_level = level_q;
  assign ovf_err    = ovf_q;
  assign wa_wr_s    = not_empty;
  // Head outputs read as zero while empty, which also gives zeros straight out of reset.
  assign wa_addr    = not_empty ? addr_mem[rd_ptr_q] : '0;
  assign wa_data_wr = not_empty ? data_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_sif_bridge_fifo.sv
// Directed bench for sif_bridge_fifo: vector table plus overflow, reset and wrap sequences.
// Expected same-cycle read value follows SIF_BRIDGE_RD_FWD_EN.
module tb_sif_bridge_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] xa_addr, xa_data_wr, xa_data_rd, wa_addr, wa_data_wr;
  logic        xa_wr_s, xa_rd_s, xa_rd_vld, xa_busy, wa_wr_s, wa_ready, ovf_err;
  logic [3:0]  fifo_level;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sif_bridge_fifo #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .DEPTH   (8),
    .NUM_REGS(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .xa_addr   (xa_addr),
    .xa_data_wr(xa_data_wr),
    .xa_wr_s   (xa_wr_s),
    .xa_rd_s   (xa_rd_s),
    .xa_data_rd(xa_data_rd),
    .xa_rd_vld (xa_rd_vld),
    .xa_busy   (xa_busy),
    .wa_addr   (wa_addr),
    .wa_data_wr(wa_data_wr),
    .wa_wr_s   (wa_wr_s),
    .wa_ready  (wa_ready),
    .fifo_level(fifo_level),
    .ovf_err   (ovf_err)
  );

  localparam logic [15:0] SameCycleRd =
`ifdef SIF_BRIDGE_RD_FWD_EN
    16'hAAAA;
`else
    16'h5555;
`endif

  typedef struct {
    logic        wr;
    logic        rd;
    logic        rdy;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        e_vld;
    logic [15:0] e_rd;
    logic        e_wv;
    logic [15:0] e_wa;
    logic [15:0] e_wd;
    logic [3:0]  e_lvl;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_head;
  int          acc, popped;
  logic        rdy_t;

  initial begin
    // wr rd rdy addr wdata | vld rd_data wv wa wd level
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'hBEEF, 4'd1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h1234, 4'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h0000, 4'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h0015, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 4'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h0015, 16'h7777, 1'b0, 16'h0000, 1'b1, 16'h0015, 16'h7777, 4'd1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h0000, 4'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h0000, 16'h0000, 4'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'h0002, 16'h5555, 1'b0, 16'h1234, 1'b1, 16'h0002, 16'h5555, 4'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'h0002, 16'hAAAA, 1'b1, SameCycleRd, 1'b1, 16'h0002, 16'hAAAA,
                4'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'h0000, 1'b1, 16'hAAAA, 1'b0, 16'h0000, 16'h0000, 4'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0004, 16'h0101, 1'b0, 16'hAAAA, 1'b1, 16'h0004, 16'h0101, 4'd1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0006, 16'h0202, 1'b0, 16'hAAAA, 1'b1, 16'h0004, 16'h0101, 4'd2};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'hAAAA, 1'b1, 16'h0006, 16'h0202, 4'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'hAAAA, 1'b0, 16'h0000, 16'h0000, 4'd0};

    rst = 1'b1; xa_addr = '0; xa_data_wr = '0; xa_wr_s = 1'b0; xa_rd_s = 1'b0; wa_ready = 1'b1;
    repeat (5) tick();
    chk("reset rd_vld", 32'(xa_rd_vld), 32'd0);
    chk("reset rd_data", 32'(xa_data_rd), 32'd0);
    chk("reset wa_wr_s", 32'(wa_wr_s), 32'd0);
    chk("reset wa_addr", 32'(wa_addr), 32'd0);
    chk("reset wa_data", 32'(wa_data_wr), 32'd0);
    chk("reset level", 32'(fifo_level), 32'd0);
    chk("reset busy", 32'(xa_busy), 32'd0);
    chk("reset ovf", 32'(ovf_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      xa_wr_s = tbl[i].wr; xa_rd_s = tbl[i].rd; wa_ready = tbl[i].rdy;
      xa_addr = tbl[i].addr; xa_data_wr = tbl[i].wdata;
      tick();
      chk($sformatf("v%0d rd_vld", i), 32'(xa_rd_vld), 32'(tbl[i].e_vld));
      chk($sformatf("v%0d rd_data", i), 32'(xa_data_rd), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d wa_wr_s", i), 32'(wa_wr_s), 32'(tbl[i].e_wv));
      chk($sformatf("v%0d wa_addr", i), 32'(wa_addr), 32'(tbl[i].e_wa));
      chk($sformatf("v%0d wa_data", i), 32'(wa_data_wr), 32'(tbl[i].e_wd));
      chk($sformatf("v%0d level", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
      chk($sformatf("v%0d busy", i), 32'(xa_busy), 32'd0);
      chk($sformatf("v%0d ovf", i), 32'(ovf_err), 32'd0);
    end
    xa_wr_s = 1'b0; xa_rd_s = 1'b0;

    // Overflow: fill with downstream stalled, drop the 9th, then drain in order.
    wa_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      xa_wr_s = 1'b1; xa_addr = 16'h0100 + 16'(k); xa_data_wr = 16'hA000 + 16'(k);
      tick();
      if (k < 8) chk($sformatf("fill level %0d", k), 32'(fifo_level), 32'(k + 1));
      if (k == 7) chk("fill busy", 32'(xa_busy), 32'd1);
    end
    chk("ovf level", 32'(fifo_level), 32'd8);
    chk("ovf flag", 32'(ovf_err), 32'd1);
    // Pop and push together while full: the push must still be rejected.
    xa_wr_s = 1'b1; xa_addr = 16'h01FF; xa_data_wr = 16'hFFFF; wa_ready = 1'b1;
    chk("drain head 0", {wa_addr, wa_data_wr}, {16'h0100, 16'hA000});
    tick();
    xa_wr_s = 1'b0;
    chk("drain level 7", 32'(fifo_level), 32'd7);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("drain vld %0d", k), 32'(wa_wr_s), 32'd1);
      chk($sformatf("drain head %0d", k), {wa_addr, wa_data_wr},
          {16'h0100 + 16'(k), 16'hA000 + 16'(k)});
      tick();
    end
    chk("drain empty vld", 32'(wa_wr_s), 32'd0);
    chk("drain empty level", 32'(fifo_level), 32'd0);
    chk("ovf sticky", 32'(ovf_err), 32'd1);

    // Reset with traffic queued: entries, shadow and flag all cleared; strobes ignored.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst clears ovf", 32'(ovf_err), 32'd0);
    xa_wr_s = 1'b1; xa_addr = 16'h0001; xa_data_wr = 16'h1111; wa_ready = 1'b1;
    tick();
    xa_wr_s = 1'b0; tick();
    wa_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      xa_wr_s = 1'b1; xa_addr = 16'h0008 + 16'(k); xa_data_wr = 16'hB000 + 16'(k);
      tick();
    end
    chk("pre-rst level", 32'(fifo_level), 32'd4);
    rst = 1'b1; xa_rd_s = 1'b1; xa_wr_s = 1'b1; xa_addr = 16'h0001; xa_data_wr = 16'h2222;
    tick();
    rst = 1'b0; xa_rd_s = 1'b0; xa_wr_s = 1'b0;
    chk("rst wa_wr_s", 32'(wa_wr_s), 32'd0);
    chk("rst level", 32'(fifo_level), 32'd0);
    chk("rst ovf", 32'(ovf_err), 32'd0);
    chk("rst rd_vld", 32'(xa_rd_vld), 32'd0);
    xa_rd_s = 1'b1; xa_addr = 16'h0001;
    tick();
    xa_rd_s = 1'b0;
    chk("rst shadow vld", 32'(xa_rd_vld), 32'd1);
    chk("rst shadow data", 32'(xa_data_rd), 32'd0);

    // Wrap: 3*DEPTH writes honouring busy while wa_ready toggles each cycle.
    acc = 0; popped = 0; rdy_t = 1'b0;
    for (int c = 0; c < 400 && popped < 24; c++) begin
      rdy_t = ~rdy_t;
      wa_ready = rdy_t;
      xa_wr_s = (acc < 24) && !xa_busy;
      if (xa_wr_s) begin
        xa_addr = 16'(acc); xa_data_wr = 16'hC000 + 16'(acc);
        exp_q.push_back({16'(acc), 16'hC000 + 16'(acc)});
        acc++;
      end
      if (wa_wr_s && wa_ready) begin
        if (exp_q.size() == 0) begin
          chk("wrap spurious head", {wa_addr, wa_data_wr}, 32'hFFFF_FFFF);
        end else begin
          exp_head = exp_q.pop_front();
          chk($sformatf("wrap head %0d", popped), {wa_addr, wa_data_wr}, exp_head);
        end
        popped++;
      end
      tick();
    end
    xa_wr_s = 1'b0;
    chk("wrap accepted", 32'(acc), 32'd24);
    chk("wrap popped", 32'(popped), 32'd24);
    chk("wrap level", 32'(fifo_level), 32'd0);
    chk("wrap ovf", 32'(ovf_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
